// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : Shared types and constants for the loadable down-counter.
//               - state_t: FSM state encoding (IDLE, COUNT, DONE)
//               - DEFAULT_DATA_WIDTH: default counter / load-value width
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : countdown_pkg
`default_nettype wire

// File: rtl/countdown_counter.sv
`default_nettype none
// ============================================================================
// Module      : countdown_counter
// Description : Loadable down-counter with a start/ready/done handshake.
//               A controller loads a count while ready; the counter then
//               decrements on every enable cycle. After reaching zero, one
//               more enable cycle produces a single-cycle done pulse.
//               A run of L therefore takes L+1 enable cycles.
//
// Optional feature (compile-time macro):
//   COUNTDOWN_AUTO_RELOAD_EN - when defined, DONE reloads the counter from
//                              the value latched at start and keeps
//                              counting; only abort or reset return to IDLE.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   load request, accepted only while ready
//   load_value in   count to run, sampled on an accepted start
//   enable     in   count qualifier
//   abort      in   cancel any operation, back to IDLE with counter 0
//   ready      out  high in IDLE
//   busy       out  high in COUNT and DONE
//   done       out  one-cycle completion pulse (high in DONE)
//   zero_count out  high in COUNT while the counter is 0
//   ctr_out    out  current counter value
//
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_counter
    import countdown_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  enable,
    input  logic                  abort,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  zero_count,
    output logic [DATA_WIDTH-1:0] ctr_out
);

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_ctr;
    logic [DATA_WIDTH-1:0] w_ctr_next;
    logic                  w_ctr_is_zero;

    assign w_ctr_is_zero = (r_ctr == '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [DATA_WIDTH-1:0] r_reload;
    logic [DATA_WIDTH-1:0] w_reload_next;
`endif

    // ------------------------------------------------------------------
    // State, counter and reload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ctr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ctr   <= w_ctr_next;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload <= '0;
        end else begin
            r_reload <= w_reload_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and next-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ctr_next   = r_ctr;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        w_reload_next = r_reload;
`endif

        // abort dominates every state, including a simultaneous start
        if (abort) begin
            w_state_next = IDLE;
            w_ctr_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_next = COUNT;
                        w_ctr_next   = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        w_reload_next = load_value;
`endif
                    end
                end

                COUNT: begin
                    // Zero is detected before decrementing, so the counter
                    // never wraps and sits at 0 through DONE.
                    if (enable) begin
                        if (w_ctr_is_zero) begin
                            w_state_next = DONE;
                        end else begin
                            w_ctr_next = r_ctr - DATA_WIDTH'(1);
                        end
                    end
                end

                DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    w_state_next = COUNT;
                    w_ctr_next   = r_reload;
`else
                    w_state_next = IDLE;
`endif
                end

                default: begin
                    w_state_next = IDLE;
                    w_ctr_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign ready      = (r_state == IDLE);
    assign busy       = (r_state == COUNT) || (r_state == DONE);
    assign done       = (r_state == DONE);
    assign zero_count = (r_state == COUNT) && w_ctr_is_zero;
    assign ctr_out    = r_ctr;

endmodule : countdown_counter
`default_nettype wire
